// File: rtl/demux_1in_2out_buf_if.sv
// Bundle of the producer-side and the two consumer-side handshakes of demux_1in_2out_buf.
// A word moves across a port on a rising edge where both its valid and its ready are high.
// A producer that raises valid keeps its data stable until the word is accepted.
interface demux_1in_2out_buf_if #(parameter int DB = 16);
  logic [DB-1:0] Entrada;
  logic          Sel;
  logic          ValidIn;
  logic          ReadyIn;
  logic [DB-1:0] SalidaA;
  logic          ValidA;
  logic          ReadyA;
  logic [DB-1:0] SalidaB;
  logic          ValidB;
  logic          ReadyB;
  logic [7:0]    CuentaA;
  logic [7:0]    CuentaB;
  // FIFO occupancies, exposed for observation
  logic [1:0]    occ_a;
  logic [1:0]    occ_b;

  modport slave (
    input  Entrada, Sel, ValidIn, ReadyA, ReadyB,
    output ReadyIn, SalidaA, ValidA, SalidaB, ValidB, CuentaA, CuentaB, occ_a, occ_b
  );

  modport master (
    output Entrada, Sel, ValidIn, ReadyA, ReadyB,
    input  ReadyIn, SalidaA, ValidA, SalidaB, ValidB, CuentaA, CuentaB, occ_a, occ_b
  );
endinterface

// File: rtl/demux_1in_2out_buf.sv
// 1-to-2 demultiplexer with an independent 2-entry FIFO and a saturating delivery counter per port.
// Index 0 of every per-port array is port A (Sel=1), index 1 is port B (Sel=0).
module demux_1in_2out_buf #(
  parameter int DB = 16
) (
  input logic                 clk,
  input logic                 reset,
  demux_1in_2out_buf_if.slave bus
);

  logic [DB-1:0] mem [2][2];
  logic [1:0]    occ [2];
  logic          wp  [2];
  logic          rp  [2];
  logic [7:0]    cnt [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ready_out;

  assign full      = {occ[1] == 2'd2, occ[0] == 2'd2};
  assign valid     = {occ[1] != 2'd0, occ[0] != 2'd0};
  assign ready_out = {bus.ReadyB, bus.ReadyA};

  // Acceptance depends only on the selected FIFO's fullness, never on the consumers.
  assign bus.ReadyIn = bus.Sel ? ~full[0] : ~full[1];

  assign push = {bus.ValidIn & ~bus.Sel & ~full[1],
                 bus.ValidIn &  bus.Sel & ~full[0]};
  assign pop  = valid & ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        occ[i] <= 2'd0;
        wp[i]  <= 1'b0;
        rp[i]  <= 1'b0;
        cnt[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          mem[i][wp[i]] <= bus.Entrada;
          wp[i]         <= ~wp[i];
        end
        if (pop[i]) begin
          rp[i] <= ~rp[i];
          if (cnt[i] != 8'd255) cnt[i] <= cnt[i] + 8'd1;
        end
        occ[i] <= occ[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end
  end

  assign bus.ValidA  = valid[0];
  assign bus.ValidB  = valid[1];
  assign bus.SalidaA = valid[0] ? mem[0][rp[0]] : '0;
  assign bus.SalidaB = valid[1] ? mem[1][rp[1]] : '0;
  assign bus.CuentaA = cnt[0];
  assign bus.CuentaB = cnt[1];
  assign bus.occ_a   = occ[0];
  assign bus.occ_b   = occ[1];

endmodule
